// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    // ARB: round-robin between core and debug; LOCK: debug owns the memory port.
    typedef enum logic [0:0] {
        ARB,
        LOCK
    } arb_state_t;

    typedef enum logic [0:0] {
        OWN_CORE,
        OWN_DBG
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_CORE) ? OWN_DBG : OWN_CORE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core port, the debug port and the shared memory port.
// slave is the arbiter's view; master is the view of the surrounding system.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = dmem_arbiter_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = dmem_arbiter_pkg::DEF_DATA_W
) ();

    // Core load/store port
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_stall;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    // Debug / loader port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_lock;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Shared memory port
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_stall, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_lock,
        output d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_stall, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata, d_lock,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-input round-robin picker: a lone request always wins, a tie goes to ptr.
// req[0]/gnt[0] is the core, req[1]/gnt[1] is debug.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     ptr,
    output logic [1:0] gnt
);

    // Combinational one-hot grant selection
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr == OWN_CORE) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core load/store path and the debug port.
// Grants are combinational from the requests; read data returns one cycle after
// the grant and is routed back to whichever port issued the read.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    arb_state_t st_q, st_d;
    owner_t     rr_q, rr_d;
    logic       rd_pend_q, rd_pend_d;
    owner_t     rd_own_q, rd_own_d;

    logic [1:0] pick_gnt;
    logic       c_gnt;
    logic       d_gnt;

    rr_pick2 u_pick (
        .req (({bus.d_req, bus.c_req})),
        .ptr (rr_q),
        .gnt (pick_gnt)
    );

    // Grant qualification, lock FSM next state and priority pointer update
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        st_d  = st_q;
        rr_d  = rr_q;
        if (!reset) begin
            unique case (st_q)
                ARB: begin
                    c_gnt = pick_gnt[0];
                    d_gnt = pick_gnt[1];
                    if (c_gnt || d_gnt) begin
                        rr_d = other_owner(d_gnt ? OWN_DBG : OWN_CORE);
                    end
                    if (d_gnt && bus.d_lock) begin
                        st_d = LOCK;
                    end
                end
                LOCK: begin
                    // Debug still owns the port in the release cycle; the core
                    // gets first pick once arbitration resumes.
                    d_gnt = bus.d_req;
                    if (!bus.d_lock) begin
                        st_d = ARB;
                        rr_d = OWN_CORE;
                    end
                end
                default: st_d = ARB;
            endcase
        end
    end

    // Remember a granted read so its data can be steered next cycle
    always_comb begin
        rd_pend_d = (c_gnt && !bus.c_we) || (d_gnt && !bus.d_we);
        rd_own_d  = d_gnt ? OWN_DBG : OWN_CORE;
    end

    // State, pointer and read-tracking registers
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= ARB;
            rr_q      <= OWN_CORE;
            rd_pend_q <= 1'b0;
            rd_own_q  <= OWN_CORE;
        end else begin
            st_q      <= st_d;
            rr_q      <= rr_d;
            rd_pend_q <= rd_pend_d;
            rd_own_q  <= rd_own_d;
        end
    end

    // Requester-side handshake
    assign bus.c_gnt   = c_gnt;
    assign bus.d_gnt   = d_gnt;
    assign bus.c_stall = bus.c_req && !c_gnt;

    // Memory port mirrors the granted requester; idle fields are driven to zero
    assign bus.m_en    = c_gnt || d_gnt;
    assign bus.m_we    = (c_gnt && bus.c_we) || (d_gnt && bus.d_we);
    assign bus.m_addr  = d_gnt ? bus.d_addr  : (c_gnt ? bus.c_addr  : '0);
    assign bus.m_wdata = d_gnt ? bus.d_wdata : (c_gnt ? bus.c_wdata : '0);

    // Response steering; a read in flight when reset hits is dropped
    assign bus.c_rvalid = rd_pend_q && !reset && (rd_own_q == OWN_CORE);
    assign bus.d_rvalid = rd_pend_q && !reset && (rd_own_q == OWN_DBG);
    assign bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;

endmodule
